spi_rx_deser: RTL and testbench
===============================

// Module: spi_rx_deser
// PURPOSE
//   Downstream consumer of the spi master's serial output (s_clk, spi_cs_l, mosi).
//   Recovers 16-bit words in the system clk domain and presents each on a valid/ready
//   port. Flags frames truncated by chip-select and words lost to back-pressure.
//   s_clk is oversampled with clk. No second clock domain is used.
// PARAMETERS
//   DATA_W       16  bits per word, 2..32.
//   SYNC_STAGES  2   synchroniser depth on s_clk/spi_cs_l/mosi, >=2.
//   MSB_FIRST    1   1: first received bit -> rx_data[DATA_W-1]; 0: -> rx_data[0].
// PORTS
//   clk        in   1                     system clock; every flop is on its rising edge.
//   rst        in   1                     asynchronous, active-low reset.
//   spi_cs_l   in   1                     chip select, active low, async to sampling.
//   s_clk      in   1                     serial clock; mosi is sampled on its rising edge.
//   mosi       in   1                     serial data.
//   rx_data    out  DATA_W                received word; stable while rx_valid=1.
//   rx_valid   out  1                     word available.
//   rx_ready   in   1                     consumer accepts; transfer when valid&&ready.
//   bit_cnt    out  $clog2(DATA_W)+1      bits received in current word (debug).
//   frame_err  out  1                     1-clk pulse: CS rose with 0<bit_cnt<DATA_W.
//   overrun    out  1                     sticky; set when a completed word is dropped.
//   ovr_clr    in   1                     synchronous clear of overrun.
// BEHAVIOUR
//   Reset (rst=0):
//     - All outputs 0. Shift register is 0. FSM goes to IDLE.
//     - Synchroniser flops reset to cs=1, s_clk=0, mosi=0.
//   Sampling:
//     - Inputs pass SYNC_STAGES flops. An s_clk rise is sync[last]=1 with prev=0.
//     - Legal input requires each s_clk high and low phase to last >=2 clk.
//   FSM:
//     - IDLE -> SHIFT when synced cs=0. bit_cnt=0.
//     - SHIFT, on each s_clk rise:
//         - Shift in mosi. bit_cnt++.
//         - On the DATA_W-th bit, the word completes and bit_cnt returns to 0.
//         - FSM stays in SHIFT, so back-to-back words under one CS are allowed.
//     - SHIFT -> IDLE when synced cs=1:
//         - If 0<bit_cnt<DATA_W: frame_err pulses for 1 clk and the partial word is discarded.
//         - bit_cnt resets to 0. The holding register is untouched.
//     - A CS rise and an s_clk rise on the same clk: the s_clk edge is ignored.
//       CS is evaluated first.
//   Output register (1 deep):
//     - Word complete and (rx_valid=0, or rx_ready=1 on the same clk):
//         - Load rx_data. rx_valid=1 on the next clk.
//         - A simultaneous handshake and load produce no bubble.
//     - Word complete with rx_valid=1 and rx_ready=0:
//         - The new word is dropped. rx_data keeps its old value. overrun is set.
//     - rx_valid stays high until a handshake. rx_data must not change while rx_valid=1.
//     - ovr_clr and an overrun event on the same clk: overrun ends up set.
//   Latency:
//     - The DATA_W-th s_clk pin rise reaches rx_valid=1 in SYNC_STAGES+2 clk.
//     - That is 4 clk at defaults.
//   Reset mid-frame: immediate return to the reset state. No frame_err pulse.
// TESTING
//   1. Reset: rst=0 during random pin activity -> all outputs 0.
//      rst=1 with cs high -> FSM holds IDLE.
//   2. Send 16'h1231 MSB first (s_clk = clk/4), rx_ready=1:
//      - rx_valid high exactly 1 clk, rx_data=16'h1231.
//      - Rise is 4 clk after the 16th s_clk edge.
//   3. One CS, words 16'h2452 then 16'h1264, rx_ready=1:
//      - Two transfers in order. No frame_err, no overrun.
//   4. rx_ready=0, send 16'hA234 then 16'h1231:
//      - rx_data stays 16'hA234 and overrun=1.
//      - ovr_clr -> overrun=0. rx_ready=1 -> a single transfer of A234.
//   5. Raise CS after 9 bits:
//      - frame_err pulses 1 clk. No rx_valid.
//      - The next full word 16'h1264 is received correctly.
//   6. Assert rst at bit 7, release, send 16'h2452:
//      - No frame_err. rx_data=16'h2452.
//   7. MSB_FIRST=0 build, send bits of 16'h1231 LSB first -> rx_data=16'h1231.

Source files
------------

// File: rtl/spi_rx_deser.sv
// -----------------------------------------------------------------------------
// spi_rx_deser
//   Receives the serial stream of an SPI master (s_clk, spi_cs_l, mosi) by
//   oversampling it with the system clock, rebuilds DATA_W-bit words and
//   hands them out on a one-deep valid/ready output register.
//
// Ports
//   clk        system clock, all flops on its rising edge
//   rst        asynchronous active-low reset
//   spi_cs_l   chip select (active low), asynchronous to clk
//   s_clk      serial clock, mosi captured on its rising edge
//   mosi       serial data
//   rx_data    received word, held stable while rx_valid is high
//   rx_valid   word available
//   rx_ready   consumer accepts (transfer on rx_valid && rx_ready)
//   bit_cnt    bits received so far in the current word
//   frame_err  one-clock pulse when CS ends a frame mid-word
//   overrun    sticky flag: a completed word was dropped (back-pressure)
//   ovr_clr    synchronous clear of overrun
// -----------------------------------------------------------------------------
module spi_rx_deser #(
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2,
    parameter int MSB_FIRST   = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      spi_cs_l,
    input  logic                      s_clk,
    input  logic                      mosi,
    output logic [DATA_W-1:0]         rx_data,
    output logic                      rx_valid,
    input  logic                      rx_ready,
    output logic [$clog2(DATA_W):0]   bit_cnt,
    output logic                      frame_err,
    output logic                      overrun,
    input  logic                      ovr_clr
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_prev;

    state_t                 r_state;
    logic [DATA_W-1:0]      r_shift;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic                   r_done;
    logic                   r_frame_err;

    logic [DATA_W-1:0]      r_rx_data;
    logic                   r_rx_valid;
    logic                   r_overrun;

    logic                   w_cs;
    logic                   w_sclk;
    logic                   w_mosi;
    logic                   w_rise;
    logic [DATA_W-1:0]      w_next_shift;

    assign w_cs   = r_cs_sync[SYNC_STAGES-1];
    assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];
    assign w_rise = w_sclk & ~r_sclk_prev;

    // Synchronise the pins; cs idles high so a reset never looks like a frame end.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cs_sync   <= {SYNC_STAGES{1'b1}};
            r_sclk_sync <= {SYNC_STAGES{1'b0}};
            r_mosi_sync <= {SYNC_STAGES{1'b0}};
            r_sclk_prev <= 1'b0;
        end else begin
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_l};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], s_clk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_sclk_prev <= w_sclk;
        end
    end

    // Shift direction decides which end of the word the first bit lands in.
    always_comb begin
        w_next_shift = r_shift;
        if (MSB_FIRST != 0) begin
            w_next_shift = {r_shift[DATA_W-2:0], w_mosi};
        end else begin
            w_next_shift = {w_mosi, r_shift[DATA_W-1:1]};
        end
    end

    // Frame FSM: CS is checked before the s_clk edge, so a coincident
    // CS rise swallows that edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_shift     <= {DATA_W{1'b0}};
            r_bit_cnt   <= {CNT_W{1'b0}};
            r_done      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_bit_cnt <= {CNT_W{1'b0}};
                    if (!w_cs) begin
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_cs) begin
                        r_state   <= ST_IDLE;
                        // bit_cnt never reaches DATA_W here, so nonzero means truncated
                        if (r_bit_cnt != {CNT_W{1'b0}}) begin
                            r_frame_err <= 1'b1;
                        end
                        r_bit_cnt <= {CNT_W{1'b0}};
                        r_shift   <= {DATA_W{1'b0}};
                    end else if (w_rise) begin
                        r_shift <= w_next_shift;
                        if (r_bit_cnt == CNT_W'(DATA_W - 1)) begin
                            r_bit_cnt <= {CNT_W{1'b0}};
                            r_done    <= 1'b1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // One-deep output register; a handshake and a new word on the same clk
    // reload without a bubble, a word arriving while full is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_data  <= {DATA_W{1'b0}};
            r_rx_valid <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (r_done && (!r_rx_valid || rx_ready)) begin
                r_rx_data  <= r_shift;
                r_rx_valid <= 1'b1;
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end else begin
                r_rx_valid <= r_rx_valid;
            end

            // A new overrun wins over a simultaneous clear.
            if (r_done && r_rx_valid && !rx_ready) begin
                r_overrun <= 1'b1;
            end else if (ovr_clr) begin
                r_overrun <= 1'b0;
            end else begin
                r_overrun <= r_overrun;
            end
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign bit_cnt   = r_bit_cnt;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_spi_rx_deser.sv
// -----------------------------------------------------------------------------
// tb_spi_rx_deser
//   Drives SPI pin traffic into two receivers sharing the same pins: one
//   built MSB-first (a), one LSB-first (b). Expected words are queued as each
//   word is sent; a negedge monitor pops and compares on every handshake.
// -----------------------------------------------------------------------------
module tb_spi_rx_deser;

    logic        clk;
    logic        rst;
    logic        spi_cs_l;
    logic        s_clk;
    logic        mosi;
    logic        rx_ready;
    logic        ovr_clr;

    logic [15:0] rx_data_a,  rx_data_b;
    logic        rx_valid_a, rx_valid_b;
    logic [4:0]  bit_cnt_a,  bit_cnt_b;
    logic        frame_err_a, frame_err_b;
    logic        overrun_a,  overrun_b;

    spi_rx_deser #(.DATA_W(16), .SYNC_STAGES(2), .MSB_FIRST(1)) u_dut_a (
        .clk(clk), .rst(rst), .spi_cs_l(spi_cs_l), .s_clk(s_clk), .mosi(mosi),
        .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready),
        .bit_cnt(bit_cnt_a), .frame_err(frame_err_a), .overrun(overrun_a),
        .ovr_clr(ovr_clr)
    );

    spi_rx_deser #(.DATA_W(16), .SYNC_STAGES(2), .MSB_FIRST(0)) u_dut_b (
        .clk(clk), .rst(rst), .spi_cs_l(spi_cs_l), .s_clk(s_clk), .mosi(mosi),
        .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready),
        .bit_cnt(bit_cnt_b), .frame_err(frame_err_b), .overrun(overrun_b),
        .ovr_clr(ovr_clr)
    );

    int total = 0;
    int bad   = 0;

    logic [15:0] q_a[$];
    logic [15:0] q_b[$];

    int cyc          = 0;
    int last_rise    = 0;
    bit check_lat    = 1'b0;
    int vhigh_a      = 0;
    int fe_a         = 0;
    int fe_b         = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] bitrev(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = v[15-i];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Queue the words each receiver should see for pin order lsb ? v[0].. : v[15]..
    task automatic push_exp(input logic [15:0] v, input bit lsb);
        if (lsb) begin
            q_a.push_back(bitrev(v));
            q_b.push_back(v);
        end else begin
            q_a.push_back(v);
            q_b.push_back(bitrev(v));
        end
    endtask

    task automatic send_bits(input logic [15:0] v, input bit lsb, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            s_clk = 1'b0;
            mosi  = lsb ? v[i] : v[15-i];
            tick(2);
            s_clk = 1'b1;
            if (i == 15) last_rise = cyc;
            tick(2);
        end
    endtask

    task automatic cs_low();
        spi_cs_l = 1'b0;
        tick(4);
    endtask

    task automatic cs_high();
        s_clk = 1'b0;
        tick(2);
        spi_cs_l = 1'b1;
        tick(6);
    endtask

    task automatic frame(input logic [15:0] v, input bit lsb);
        cs_low();
        push_exp(v, lsb);
        send_bits(v, lsb, 16);
        cs_high();
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while (((q_a.size() + q_b.size()) != 0) && (k < 80)) begin
            tick(1);
            k++;
        end
        chk(name, 32'(q_a.size() + q_b.size()), 32'd0);
    endtask

    // Monitor: compares each handshake against the queued expectation.
    initial begin
        bit          prev_va = 1'b0;
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (rx_valid_a) vhigh_a++;
            if (frame_err_a) fe_a++;
            if (frame_err_b) fe_b++;
            if (rx_valid_a && !prev_va && check_lat)
                chk("latency_a", 32'(cyc - last_rise), 32'd4);
            prev_va = rx_valid_a;
            if (rx_valid_a && rx_ready) begin
                if (q_a.size() == 0) chk("unexpected_a", {16'd0, rx_data_a}, 32'hDEAD_0000);
                else begin
                    e = q_a.pop_front();
                    chk("data_a", {16'd0, rx_data_a}, {16'd0, e});
                end
            end
            if (rx_valid_b && rx_ready) begin
                if (q_b.size() == 0) chk("unexpected_b", {16'd0, rx_data_b}, 32'hDEAD_0000);
                else begin
                    e = q_b.pop_front();
                    chk("data_b", {16'd0, rx_data_b}, {16'd0, e});
                end
            end
        end
    end

    initial begin
        int v0, f0a, f0b;
        rst      = 1'b0;
        spi_cs_l = 1'b1;
        s_clk    = 1'b0;
        mosi     = 1'b0;
        rx_ready = 1'b1;
        ovr_clr  = 1'b0;

        // 1. reset under random pin activity
        for (int i = 0; i < 8; i++) begin
            spi_cs_l = 1'($urandom_range(0, 1));
            s_clk    = 1'($urandom_range(0, 1));
            mosi     = 1'($urandom_range(0, 1));
            tick(1);
            if (i % 4 == 3) begin
                chk("rst_outs_a", {8'd0, rx_data_a, rx_valid_a, bit_cnt_a, frame_err_a, overrun_a}, 32'd0);
                chk("rst_outs_b", {8'd0, rx_data_b, rx_valid_b, bit_cnt_b, frame_err_b, overrun_b}, 32'd0);
            end
        end
        spi_cs_l = 1'b1;
        s_clk    = 1'b0;
        mosi     = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(6);
        chk("idle_a", {26'd0, rx_valid_a, bit_cnt_a}, 32'd0);
        chk("idle_fe", 32'(fe_a + fe_b), 32'd0);

        // 2. single word, latency and one-clock valid
        v0 = vhigh_a;
        check_lat = 1'b1;
        frame(16'h1231, 1'b0);
        wait_drain("drain_t2");
        check_lat = 1'b0;
        chk("valid_width", 32'(vhigh_a - v0), 32'd1);

        // 3. two words under one CS
        f0a = fe_a;
        cs_low();
        push_exp(16'h2452, 1'b0);
        send_bits(16'h2452, 1'b0, 16);
        push_exp(16'h1264, 1'b0);
        send_bits(16'h1264, 1'b0, 16);
        cs_high();
        wait_drain("drain_t3");
        chk("t3_no_fe", 32'(fe_a - f0a), 32'd0);
        chk("t3_no_ovr", {30'd0, overrun_a, overrun_b}, 32'd0);

        // 4. back-pressure: second word dropped
        rx_ready = 1'b0;
        cs_low();
        push_exp(16'hA234, 1'b0);
        send_bits(16'hA234, 1'b0, 16);
        send_bits(16'h1231, 1'b0, 16);
        cs_high();
        chk("t4_hold_a", {16'd0, rx_data_a}, 32'h0000_A234);
        chk("t4_hold_b", {16'd0, rx_data_b}, {16'd0, bitrev(16'hA234)});
        chk("t4_ovr", {30'd0, overrun_a, overrun_b}, 32'd3);
        ovr_clr = 1'b1;
        tick(1);
        ovr_clr = 1'b0;
        tick(1);
        chk("t4_ovr_clr", {30'd0, overrun_a, overrun_b}, 32'd0);
        rx_ready = 1'b1;
        wait_drain("drain_t4");
        tick(2);
        chk("t4_valid_low", {31'd0, rx_valid_a}, 32'd0);

        // 5. truncated frame after 9 bits
        v0  = vhigh_a;
        f0a = fe_a;
        f0b = fe_b;
        cs_low();
        send_bits(16'hFFFF, 1'b0, 9);
        s_clk = 1'b0;
        tick(2);
        chk("t5_bit_cnt", {27'd0, bit_cnt_a}, 32'd9);
        spi_cs_l = 1'b1;
        tick(6);
        chk("t5_fe_a", 32'(fe_a - f0a), 32'd1);
        chk("t5_fe_b", 32'(fe_b - f0b), 32'd1);
        chk("t5_no_valid", 32'(vhigh_a - v0), 32'd0);
        frame(16'h1264, 1'b0);
        wait_drain("drain_t5");

        // 6. reset at bit 7
        f0a = fe_a;
        cs_low();
        send_bits(16'h5555, 1'b0, 7);
        rst      = 1'b0;
        spi_cs_l = 1'b1;
        tick(1);
        chk("t6_rst_outs", {8'd0, rx_data_a, rx_valid_a, bit_cnt_a, frame_err_a, overrun_a}, 32'd0);
        tick(2);
        rst = 1'b1;
        tick(4);
        chk("t6_no_fe", 32'(fe_a - f0a), 32'd0);
        frame(16'h2452, 1'b0);
        wait_drain("drain_t6");
        chk("t6_data", {16'd0, rx_data_a}, 32'h0000_2452);

        // 7. LSB-first pin order into the LSB-first build
        frame(16'h1231, 1'b1);
        wait_drain("drain_t7");
        chk("t7_data_b", {16'd0, rx_data_b}, 32'h0000_1231);

        tick(4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
